cmd_issue_ctrl: RTL
===================

# cmd_issue_ctrl

Host-side command sequencer between the SDHCI register file and `cmd_logic`. It turns Command-register writes into a valid/ready transaction toward `cmd_logic` and maintains Command Inhibit (CMD). It collects the result into the 128-bit Response register image and raises the command-complete/error interrupt-status pulses. With the macro below it can also issue Auto CMD12 after a data transfer.

## Interface
- Parameter `AutoCmdIdx`, default 6'd12: command index used for the automatic stop command.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_reg_wr_i` in 1: one-cycle strobe, software wrote the Command register.
- `cmd_index_i` in 6: command index.
- `cmd_abort_i` in 1: command type is Abort.
- `data_present_i` in 1: data present select.
- `index_check_en_i` in 1: command index check enable.
- `crc_check_en_i` in 1: command CRC check enable.
- `response_type_i` in `sdhci_pkg::response_type_e`: response type.
- `argument_i` in 32: Argument register.
- `dat_inhibit_i` in 1: DAT line busy, from the data path.
- `cmd_inhibit_o` out 1: Present State bit 0.
- `cmd_o` out 6, `cmd_arg_o` out 32, `response_type_o` out enum, `cmd_valid_o` out 1, `cmd_ready_i` in 1: request toward `cmd_logic`.
- `cmd_done_i` in 1, `cmd_result_valid_i` in 1, `rsp_i` in 120: results from `cmd_logic`.
- `index_error_i`, `end_bit_error_i`, `crc_error_i`, `timeout_error_i` in 1 each: error inputs from `cmd_logic`.
- `response_o` out 128: Response register image.
- `cmd_complete_o`, `cmd_timeout_err_o`, `cmd_crc_err_o`, `cmd_end_bit_err_o`, `cmd_index_err_o` out 1 each: one-cycle status pulses.
- `xfer_done_i` in 1, `auto_cmd12_en_i` in 1: transfer finished; Transfer Mode Auto CMD12 enable.
- `auto_cmd12_err_o` out 5: Auto CMD12 error status, bits {index, end bit, CRC, timeout, not-executed}.
- `auto_cmd12_done_o` out 1: one-cycle pulse when Auto CMD12 completes.

## Operation
- States: IDLE, ISSUE, WAIT_RESULT, AUTO_ISSUE, AUTO_WAIT. All outputs reset to 0 and the state resets to IDLE.
- **Accepting a write.** A write is accepted in IDLE only. It is dropped silently in either of these cases:
  - `cmd_inhibit_o` is high.
  - `data_present_i` is set or the response type is RESPONSE_LENGTH_48_CHECK_BUSY, `dat_inhibit_i` is high, and `cmd_abort_i` is low.
- **On accept.** Latch index, argument and response type, plus the two check enables. Go to ISSUE and set `cmd_inhibit_o`.
- **ISSUE.** `cmd_valid_o` is high and the payload is stable until `cmd_ready_i`. On handshake go to WAIT_RESULT.
- **WAIT_RESULT, NO_RESPONSE.** On `cmd_done_i`, complete.
- **WAIT_RESULT, other types, timeout.** On `timeout_error_i`, pulse `cmd_timeout_err_o` together with `cmd_complete_o`. `response_o` is unchanged.
- **WAIT_RESULT, other types, result.** On `cmd_result_valid_i`, update `response_o`:
  - RESPONSE_LENGTH_136: `response_o[119:0]` = `rsp_i` and `[127:120]` = 0.
  - 48-bit types: `response_o[31:0]` = `rsp_i[31:0]`; the upper bits are retained.
- **Error sampling.** Sample the error inputs in the `cmd_result_valid_i` cycle only. CRC is masked by the latched `crc_check_en`, index by the latched `index_check_en`; end bit is never masked.
- **Completion.** Pulse `cmd_complete_o` and return to IDLE, clearing `cmd_inhibit_o`.
- **Auto CMD12 request.** `xfer_done_i` while `auto_cmd12_en_i` is high sets a pending flag; the flag is held if the block is busy. From IDLE with the flag set, go to AUTO_ISSUE with `cmd_o` = `AutoCmdIdx`, argument 0 and RESPONSE_LENGTH_48_CHECK_BUSY. `cmd_inhibit_o` stays high throughout.
- **Auto CMD12 result.** `rsp_i[31:0]` goes to `response_o[127:96]`. Errors go to `auto_cmd12_err_o`; CRC and index checking are always on. Then pulse `auto_cmd12_done_o`. `cmd_complete_o` is not pulsed.
- **Auto CMD12 not executed.** If `dat_inhibit_i` is low when the flag is serviced, skip the command and set bit 0 (not-executed) of `auto_cmd12_err_o`.
- `auto_cmd12_err_o` is held until the next Auto CMD12 starts.

## Timing
- Accepting write in cycle N: `cmd_inhibit_o` and `cmd_valid_o` are high from N+1.
- A result input in cycle M gives `response_o` updated and status pulses in M+1. `cmd_inhibit_o` is low from M+1, so the earliest accepted next write is in M+1.
- A write coinciding with the result cycle M is dropped.
- When a pending Auto CMD12 and a software write are both ready in IDLE, Auto CMD12 wins and the write is dropped.
- `xfer_done_i` while the flag is already set: no effect.
- Reset mid-transaction: `cmd_valid_o` drops asynchronously and the pending flag clears. `cmd_logic` is reset by the same reset.

## Configuration
- `SDHCI_AUTO_CMD12_EN` defined: pending flag, AUTO_ISSUE and AUTO_WAIT exist.
- Undefined: `xfer_done_i` and `auto_cmd12_en_i` are ignored, `auto_cmd12_err_o` and `auto_cmd12_done_o` are tied 0, and `response_o[127:96]` changes only via R2 responses.

## Structure
- `sdhci_pkg` holds:
  - `cmd_t`, `cmd_arg_t` and `response_type_e`.
  - A new `cmd_issue_state_e`.
  - `AUTO_CMD12_ERR_W` = 5.
- Single module, no sub-module. The response mapping is inline combinational logic.

## Test plan
- CMD0, NO_RESPONSE: write, ready after 3 cycles, then `cmd_done_i` → `cmd_complete_o` one pulse; `response_o` stays 0; inhibit clears.
- CMD17, 48-bit, `rsp_i[31:0]`=32'h0000_0900, `crc_error_i`=1 with CRC check on → `response_o[31:0]`=32'h900 and `cmd_crc_err_o`+`cmd_complete_o`. Repeat with check off → no CRC error.
- CMD2, R2, `rsp_i`=120'hA5…5A → `response_o` = {8'h0, `rsp_i`}. With `timeout_error_i` instead → timeout pulse and `response_o` unchanged.
- Write while inhibit is high, and R1b write with `dat_inhibit_i`=1 → no `cmd_valid_o`, no state change. The same R1b with `cmd_abort_i`=1 is issued.
- Auto CMD12 (macro on): `xfer_done_i` during a CMD13 → CMD13 completes, then CMD12 is issued with arg 0; `response_o[127:96]` is written and `auto_cmd12_done_o` pulses.
- Reset asserted in ISSUE → `cmd_valid_o`=0 and `cmd_inhibit_o`=0 immediately.

Source files
------------

// File: rtl/sdhci_pkg.sv
// Shared SDHCI types: command index/argument, response type encoding,
// command-issue FSM states and Auto CMD12 error-status width.
package sdhci_pkg;

    typedef logic [5:0]  cmd_t;
    typedef logic [31:0] cmd_arg_t;

    // Encoding matches the Command register Response Type Select field.
    typedef enum logic [1:0] {
        NO_RESPONSE                   = 2'b00,
        RESPONSE_LENGTH_136           = 2'b01,
        RESPONSE_LENGTH_48            = 2'b10,
        RESPONSE_LENGTH_48_CHECK_BUSY = 2'b11
    } response_type_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RESULT,
        AUTO_ISSUE,
        AUTO_WAIT
    } cmd_issue_state_e;

    // Auto CMD12 error bits: {index, end bit, CRC, timeout, not-executed}.
    localparam int AUTO_CMD12_ERR_W = 5;

endpackage

// File: rtl/cmd_issue_ctrl.sv
// Host-side command sequencer: turns Command-register writes into a
// valid/ready request toward cmd_logic, owns Command Inhibit (CMD), builds
// the 128-bit Response register image and raises status pulses.
// Optional macro SDHCI_AUTO_CMD12_EN adds automatic CMD12 after transfers.
module cmd_issue_ctrl
    import sdhci_pkg::*;
#(
    parameter cmd_t AutoCmdIdx = 6'd12
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // Command register interface
    input  logic                        cmd_reg_wr_i,
    input  logic [5:0]                  cmd_index_i,
    input  logic                        cmd_abort_i,
    input  logic                        data_present_i,
    input  logic                        index_check_en_i,
    input  logic                        crc_check_en_i,
    input  response_type_e              response_type_i,
    input  logic [31:0]                 argument_i,
    input  logic                        dat_inhibit_i,
    output logic                        cmd_inhibit_o,
    // Request toward cmd_logic
    output logic [5:0]                  cmd_o,
    output logic [31:0]                 cmd_arg_o,
    output response_type_e              response_type_o,
    output logic                        cmd_valid_o,
    input  logic                        cmd_ready_i,
    // Results from cmd_logic
    input  logic                        cmd_done_i,
    input  logic                        cmd_result_valid_i,
    input  logic [119:0]                rsp_i,
    input  logic                        index_error_i,
    input  logic                        end_bit_error_i,
    input  logic                        crc_error_i,
    input  logic                        timeout_error_i,
    // Response register and status pulses
    output logic [127:0]                response_o,
    output logic                        cmd_complete_o,
    output logic                        cmd_timeout_err_o,
    output logic                        cmd_crc_err_o,
    output logic                        cmd_end_bit_err_o,
    output logic                        cmd_index_err_o,
    // Auto CMD12
    input  logic                        xfer_done_i,
    input  logic                        auto_cmd12_en_i,
    output logic [AUTO_CMD12_ERR_W-1:0] auto_cmd12_err_o,
    output logic                        auto_cmd12_done_o
);

    cmd_issue_state_e state_q, state_d;

    cmd_t           cmd_q;
    cmd_arg_t       arg_q;
    response_type_e rtype_q;
    logic           idx_chk_q;
    logic           crc_chk_q;
    logic           auto_pend;

    logic           dat_guard;
    logic           wr_ok;
    logic           accept;
    logic           std_done;
    logic           std_rsp;
    logic           std_tmo;
    logic           auto_start;
    logic           auto_skip;
    logic           auto_rsp;
    logic           auto_tmo;
    logic [127:0]   response_d;

    assign cmd_o           = cmd_q;
    assign cmd_arg_o       = arg_q;
    assign response_type_o = rtype_q;

    // Commands that use DAT (data or busy) must wait for the data path,
    // unless they are the Abort command meant to stop it.
    assign dat_guard = (data_present_i || response_type_i == RESPONSE_LENGTH_48_CHECK_BUSY)
                       && dat_inhibit_i && !cmd_abort_i;
    assign wr_ok     = cmd_reg_wr_i && !cmd_inhibit_o && !dat_guard;

    // State register; reset lands in IDLE so valid/inhibit drop immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every flop samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic plus the one-cycle event strobes the datapath consumes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d    = state_q;
        accept     = 1'b0;
        std_done   = 1'b0;
        std_rsp    = 1'b0;
        std_tmo    = 1'b0;
        auto_start = 1'b0;
        auto_skip  = 1'b0;
        auto_rsp   = 1'b0;
        auto_tmo   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pending Auto CMD12 has priority; a coincident write is dropped.
                if (auto_pend) begin
                    if (dat_inhibit_i) begin
                        auto_start = 1'b1;
                        state_d    = AUTO_ISSUE;
                    end else begin
                        auto_skip = 1'b1;
                    end
                end else if (wr_ok) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready_i) state_d = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (rtype_q == NO_RESPONSE) begin
                    std_done = cmd_done_i;
                end else if (cmd_result_valid_i) begin
                    std_done = 1'b1;
                    std_rsp  = 1'b1;
                end else if (timeout_error_i) begin
                    std_done = 1'b1;
                    std_tmo  = 1'b1;
                end
                if (std_done) state_d = IDLE;
            end
            AUTO_ISSUE: begin
                if (cmd_ready_i) state_d = AUTO_WAIT;
            end
            AUTO_WAIT: begin
                if (cmd_result_valid_i) begin
                    auto_rsp = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_error_i) begin
                    auto_tmo = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request handshake and Command Inhibit follow the state directly.
    always_comb begin
        cmd_valid_o   = (state_q == ISSUE) || (state_q == AUTO_ISSUE);
        cmd_inhibit_o = (state_q != IDLE);
    end

    // Response register mapping: R2 fills 119:0, 48-bit types only 31:0,
    // and the Auto CMD12 response lands in the top word.
    always_comb begin
        response_d = response_o;
`ifdef SDHCI_AUTO_CMD12_EN
        if (state_q == AUTO_WAIT) begin
            response_d[127:96] = rsp_i[31:0];
        end else
`endif
        if (rtype_q == RESPONSE_LENGTH_136) begin
            response_d = {8'h00, rsp_i};
        end else begin
            response_d[31:0] = rsp_i[31:0];
        end
    end

    // Command payload latch, response image and software-command status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q             <= '0;
            arg_q             <= '0;
            rtype_q           <= NO_RESPONSE;
            idx_chk_q         <= 1'b0;
            crc_chk_q         <= 1'b0;
            response_o        <= '0;
            cmd_complete_o    <= 1'b0;
            cmd_timeout_err_o <= 1'b0;
            cmd_crc_err_o     <= 1'b0;
            cmd_end_bit_err_o <= 1'b0;
            cmd_index_err_o   <= 1'b0;
        end else begin
            cmd_complete_o    <= std_done;
            cmd_timeout_err_o <= std_tmo;
            cmd_crc_err_o     <= std_rsp & crc_error_i & crc_chk_q;
            cmd_end_bit_err_o <= std_rsp & end_bit_error_i;
            cmd_index_err_o   <= std_rsp & index_error_i & idx_chk_q;

            if (accept) begin
                cmd_q     <= cmd_index_i;
                arg_q     <= argument_i;
                rtype_q   <= response_type_i;
                idx_chk_q <= index_check_en_i;
                crc_chk_q <= crc_check_en_i;
            end
`ifdef SDHCI_AUTO_CMD12_EN
            else if (auto_start) begin
                cmd_q   <= AutoCmdIdx;
                arg_q   <= '0;
                rtype_q <= RESPONSE_LENGTH_48_CHECK_BUSY;
            end

            if (std_rsp || auto_rsp) response_o <= response_d;
`else
            if (std_rsp) response_o <= response_d;
`endif
        end
    end

`ifdef SDHCI_AUTO_CMD12_EN
    // Auto CMD12 pending flag, error status (held until the next one) and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            auto_pend         <= 1'b0;
            auto_cmd12_err_o  <= '0;
            auto_cmd12_done_o <= 1'b0;
        end else begin
            auto_cmd12_done_o <= auto_rsp | auto_tmo;

            if (auto_start || auto_skip) begin
                auto_pend <= 1'b0;
            end else if (xfer_done_i && auto_cmd12_en_i) begin
                auto_pend <= 1'b1;
            end

            if (auto_start) begin
                auto_cmd12_err_o <= '0;
            end else if (auto_skip) begin
                auto_cmd12_err_o <= AUTO_CMD12_ERR_W'(5'b00001);
            end else if (auto_rsp) begin
                auto_cmd12_err_o <= {index_error_i, end_bit_error_i, crc_error_i, 2'b00};
            end else if (auto_tmo) begin
                auto_cmd12_err_o <= AUTO_CMD12_ERR_W'(5'b00010);
            end
        end
    end
`else
    // Without the feature the flag never sets and the auto outputs stay low.
    logic unused_auto;
    assign auto_pend         = 1'b0;
    assign auto_cmd12_err_o  = '0;
    assign auto_cmd12_done_o = 1'b0;
    assign unused_auto       = xfer_done_i ^ auto_cmd12_en_i ^ (^AutoCmdIdx)
                               ^ auto_start ^ auto_skip ^ auto_rsp ^ auto_tmo;
`endif

endmodule
